fwb_master_monitor: RTL and testbench

Passive Wishbone (pipelined, B4) bus-protocol monitor bound alongside any bus master, e.g. the instruction-prefetch unit. It tracks requests and acknowledgements within a bus cycle and reports the outstanding-transaction count. It checks every master-side and slave-side protocol rule, with each rule tunable by parameters. It drives nothing on the bus; its only outputs are counters and a sticky violation flag.

---
 rtl/fwb_pkg.sv | 7 +
 rtl/fwb_timeout_counter.sv | 27 ++
 rtl/fwb_master_monitor.sv | 152 +++++++++++++++
 tb/tb_fwb_master_monitor.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwb_pkg.sv
// Shared constants for the Wishbone master-side protocol monitor.
package fwb_pkg;
  localparam int VIOL_MASTER = 0;
  localparam int VIOL_SLAVE  = 1;
  localparam int VIOL_W      = 2;
  localparam int TMR_W       = 32;
endpackage

// File: rtl/fwb_timeout_counter.sv
// Run-length timer: counts consecutive enabled cycles and flags the cycle
// in which the run would pass the limit (limit of 0 disables the flag).
module fwb_timeout_counter
  import fwb_pkg::*;
#(
  parameter int CW = TMR_W
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          inc,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic          exceed
);
  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset || clr)
      count <= '0;
    else if (inc && count != '1)
      count <= count + CW'(1);
  end

  // Flag on the edge that would take the run past the limit, so the sticky
  // bit becomes visible the cycle after the offending one.
  assign exceed = (limit != '0) && inc && (count >= limit);
endmodule

// File: rtl/fwb_master_monitor.sv
// Passive pipelined Wishbone monitor: counts requests/responses in a bus
// cycle and records sticky master/slave protocol violations.
module fwb_master_monitor
  import fwb_pkg::*;
#(
  parameter int AW                   = 32,
  parameter int DW                   = 32,
  parameter int F_LGDEPTH            = 4,
  parameter int F_MAX_STALL          = 0,
  parameter int F_MAX_ACK_DELAY      = 0,
  parameter int F_OPT_RMW_BUS_OPTION = 1,
  parameter int F_OPT_DISCONTINUOUS  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic [DW-1:0]        i_wb_idata,
  input  logic                 i_wb_err,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic [VIOL_W-1:0]    f_violation
);
  logic req, resp;
  logic after_reset, past_cyc, past_stb, past_hold, past_err, past_idle;
  logic seen_stb, stb_dropped;
  logic            past_we;
  logic [AW-1:0]   past_addr;
  logic [DW-1:0]   past_data;
  logic [DW/8-1:0] past_sel;
  logic stall_inc, delay_inc, stall_exceed, delay_exceed;
  logic master_bad, slave_bad;
  logic [VIOL_W-1:0] viol_now;
  logic unused_idata;

  assign unused_idata = ^i_wb_idata;

  assign req  = i_wb_cyc && i_wb_stb && !i_wb_stall;
  assign resp = i_wb_cyc && (i_wb_ack || i_wb_err);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      f_nreqs <= '0;
      f_nacks <= '0;
    end else begin
      if (req)  f_nreqs <= f_nreqs + F_LGDEPTH'(1);
      if (resp) f_nacks <= f_nacks + F_LGDEPTH'(1);
    end
  end

  assign f_outstanding = i_wb_cyc ? (f_nreqs - f_nacks) : '0;

  // One-cycle history of the bus used by the sequential rules.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      after_reset <= 1'b1;
      past_cyc    <= 1'b0;
      past_stb    <= 1'b0;
      past_hold   <= 1'b0;
      past_err    <= 1'b0;
      past_idle   <= 1'b0;
    end else begin
      after_reset <= 1'b0;
      past_cyc    <= i_wb_cyc;
      past_stb    <= i_wb_cyc && i_wb_stb;
      past_hold   <= i_wb_cyc && i_wb_stb && i_wb_stall;
      past_err    <= i_wb_cyc && i_wb_err;
      past_idle   <= i_wb_cyc && !i_wb_stb && (f_outstanding == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    past_we   <= i_wb_we;
    past_addr <= i_wb_addr;
    past_data <= i_wb_data;
    past_sel  <= i_wb_sel;
  end

  // Tracks whether STB has already fallen inside the current bus cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      seen_stb    <= 1'b0;
      stb_dropped <= 1'b0;
    end else begin
      if (i_wb_stb) seen_stb <= 1'b1;
      if (seen_stb && !i_wb_stb) stb_dropped <= 1'b1;
    end
  end

  assign stall_inc = i_wb_cyc && i_wb_stb && i_wb_stall;
  assign delay_inc = i_wb_cyc && (f_outstanding != '0) && !resp;

  fwb_timeout_counter u_stall_tmr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (stall_inc),
    .clr     (!stall_inc),
    .limit   (TMR_W'(F_MAX_STALL)),
    .exceed  (stall_exceed)
  );

  fwb_timeout_counter u_delay_tmr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (delay_inc),
    .clr     (!delay_inc),
    .limit   (TMR_W'(F_MAX_ACK_DELAY)),
    .exceed  (delay_exceed)
  );

  always_comb begin
    master_bad = 1'b0;
    if (i_wb_stb && !i_wb_cyc) master_bad = 1'b1;
    if (after_reset && (i_wb_cyc || i_wb_stb)) master_bad = 1'b1;
    if (past_hold && i_wb_cyc && (!i_wb_stb || i_wb_addr != past_addr ||
        i_wb_we != past_we || i_wb_data != past_data || i_wb_sel != past_sel))
      master_bad = 1'b1;
    if (past_stb && i_wb_cyc && i_wb_stb && i_wb_we != past_we) master_bad = 1'b1;
    if ((F_OPT_DISCONTINUOUS == 0) && i_wb_cyc && i_wb_stb && stb_dropped)
      master_bad = 1'b1;
    if ((F_OPT_RMW_BUS_OPTION == 0) && past_idle && i_wb_cyc) master_bad = 1'b1;
    if (past_err && i_wb_cyc) master_bad = 1'b1;
    if (req && (&f_nreqs)) master_bad = 1'b1;
  end

  // The cycle CYC falls may still carry a late ack; only flag stray
  // responses once CYC was already low on the previous cycle.
  always_comb begin
    slave_bad = 1'b0;
    if (!i_wb_cyc && !past_cyc && (i_wb_ack || i_wb_err)) slave_bad = 1'b1;
    if (resp && (f_outstanding == '0) && !req) slave_bad = 1'b1;
    if (stall_exceed || delay_exceed) slave_bad = 1'b1;
  end

  always_comb begin
    viol_now              = '0;
    viol_now[VIOL_MASTER] = master_bad;
    viol_now[VIOL_SLAVE]  = slave_bad;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) f_violation <= '0;
    else         f_violation <= f_violation | viol_now;
  end
endmodule

// File: tb/tb_fwb_master_monitor.sv
// Bench: directed protocol scenarios plus randomized bus episodes, two
// monitor configurations checked against a cycle-level reference model.
module tb_fwb_master_monitor;
  typedef struct packed {
    logic        cyc, stb, we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    logic        ack, stall, err;
    logic [31:0] idata;
  } bus_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  bus_t b;
  logic [3:0] x_nreqs, x_nacks, x_out, y_nreqs, y_nacks, y_out;
  logic [1:0] x_viol, y_viol;

  // x: strict strobe, timers 3/2; y: discontinuous strobe, no idle CYC, no timers
  fwb_master_monitor #(.F_MAX_STALL(3), .F_MAX_ACK_DELAY(2),
    .F_OPT_RMW_BUS_OPTION(1), .F_OPT_DISCONTINUOUS(0)) u_x (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(b.cyc), .i_wb_stb(b.stb),
    .i_wb_we(b.we), .i_wb_addr(b.addr), .i_wb_data(b.data), .i_wb_sel(b.sel),
    .i_wb_ack(b.ack), .i_wb_stall(b.stall), .i_wb_idata(b.idata),
    .i_wb_err(b.err), .f_nreqs(x_nreqs), .f_nacks(x_nacks),
    .f_outstanding(x_out), .f_violation(x_viol));

  fwb_master_monitor #(.F_MAX_STALL(0), .F_MAX_ACK_DELAY(0),
    .F_OPT_RMW_BUS_OPTION(0), .F_OPT_DISCONTINUOUS(1)) u_y (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(b.cyc), .i_wb_stb(b.stb),
    .i_wb_we(b.we), .i_wb_addr(b.addr), .i_wb_data(b.data), .i_wb_sel(b.sel),
    .i_wb_ack(b.ack), .i_wb_stall(b.stall), .i_wb_idata(b.idata),
    .i_wb_err(b.err), .f_nreqs(y_nreqs), .f_nacks(y_nacks),
    .f_outstanding(y_out), .f_violation(y_viol));

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  int cfg_disc[2]  = '{0, 1};
  int cfg_rmw[2]   = '{1, 0};
  int cfg_stall[2] = '{3, 0};
  int cfg_delay[2] = '{2, 0};

  int   m_reqs, m_acks, m_stall_run, m_wait_run, m_phase, m_prev_out;
  bit   m_first;
  bus_t m_prev;
  logic [1:0] m_viol [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: rules evaluated over the current sample and last sample.
  task automatic model_update();
    int  out;
    bit  req, resp;
    logic [1:0] v;
    if (rst) begin
      m_reqs = 0; m_acks = 0; m_stall_run = 0; m_wait_run = 0; m_phase = 0;
      m_prev_out = 0; m_first = 1; m_prev = '0;
      m_viol[0] = 2'b00; m_viol[1] = 2'b00;
      return;
    end
    out  = b.cyc ? ((m_reqs - m_acks) & 15) : 0;
    req  = b.cyc && b.stb && !b.stall;
    resp = b.cyc && (b.ack || b.err);
    for (int c = 0; c < 2; c++) begin
      v = 2'b00;
      if ((b.stb && !b.cyc) || (m_first && (b.cyc || b.stb)) ||
          (m_prev.cyc && m_prev.stb && m_prev.stall && b.cyc &&
           (!b.stb || b.addr != m_prev.addr || b.we != m_prev.we ||
            b.data != m_prev.data || b.sel != m_prev.sel)) ||
          (m_prev.cyc && m_prev.stb && b.cyc && b.stb && b.we != m_prev.we) ||
          (m_prev.cyc && m_prev.err && b.cyc) || (req && m_reqs == 15))
        v[0] = 1'b1;
      if (cfg_disc[c] == 0 && b.cyc && b.stb && m_phase == 2) v[0] = 1'b1;
      if (cfg_rmw[c] == 0 && m_prev.cyc && !m_prev.stb && m_prev_out == 0 && b.cyc)
        v[0] = 1'b1;
      if (!b.cyc && !m_prev.cyc && (b.ack || b.err)) v[1] = 1'b1;
      if (resp && out == 0 && !req) v[1] = 1'b1;
      if (cfg_stall[c] != 0 && b.cyc && b.stb && b.stall && m_stall_run + 1 > cfg_stall[c])
        v[1] = 1'b1;
      if (cfg_delay[c] != 0 && b.cyc && out > 0 && !resp && m_wait_run + 1 > cfg_delay[c])
        v[1] = 1'b1;
      m_viol[c] = m_viol[c] | v;
    end
    m_stall_run = (b.cyc && b.stb && b.stall) ? m_stall_run + 1 : 0;
    m_wait_run  = (b.cyc && out > 0 && !resp) ? m_wait_run + 1 : 0;
    if (!b.cyc) begin
      m_reqs = 0; m_acks = 0; m_phase = 0;
    end else begin
      m_reqs = (m_reqs + int'(req)) % 16;
      m_acks = (m_acks + int'(resp)) % 16;
      if (m_phase == 0 && b.stb) m_phase = 1;
      else if (m_phase == 1 && !b.stb) m_phase = 2;
    end
    m_prev = b; m_prev_out = out; m_first = 0;
  endtask

  task automatic step();
    int e_out;
    @(negedge clk);
    if (chk_en) begin
      e_out = b.cyc ? ((m_reqs - m_acks) & 15) : 0;
      chk("x.nreqs", 32'(x_nreqs), 32'(m_reqs));
      chk("x.nacks", 32'(x_nacks), 32'(m_acks));
      chk("x.outstanding", 32'(x_out), 32'(e_out));
      chk("x.violation", 32'(x_viol), 32'(m_viol[0]));
      chk("y.nreqs", 32'(y_nreqs), 32'(m_reqs));
      chk("y.outstanding", 32'(y_out), 32'(e_out));
      chk("y.violation", 32'(y_viol), 32'(m_viol[1]));
    end
    model_update();
    @(posedge clk); #1;
  endtask

  task automatic bus(input logic c, s, st, a, e, input logic [31:0] ad);
    b.cyc = c; b.stb = s; b.stall = st; b.ack = a; b.err = e;
    b.we = 1'b0; b.addr = ad; b.data = ad + 32'h1; b.sel = 4'hf;
    b.idata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; step();
    b = '0; rst = 1'b0;
  endtask

  task automatic chaos();
    case ($urandom_range(0, 6))
      0: b.cyc = ~b.cyc;
      1: b.stb = ~b.stb;
      2: b.ack = ~b.ack;
      3: b.err = ~b.err;
      4: b.we = ~b.we;
      5: b.addr[2] = ~b.addr[2];
      default: b.stall = ~b.stall;
    endcase
  endtask

  task automatic episode();
    int nreq, sent, acked, ncyc;
    logic we_e;
    bit abort, erred;
    do_reset();
    repeat ($urandom_range(1, 2)) step();
    nreq = $urandom_range(1, 6); we_e = ($urandom_range(0, 1) == 1);
    sent = 0; acked = 0; ncyc = 0; erred = 0;
    abort = ($urandom_range(0, 7) == 0);
    while (acked < nreq && ncyc < 30 && !erred) begin
      b.cyc = 1'b1; b.we = we_e; b.stb = (sent < nreq);
      b.addr = 32'h100 + 32'(sent * 4); b.data = 32'hD000_0000 + 32'(sent);
      b.sel = 4'hf; b.idata = $urandom;
      b.stall = b.stb && ($urandom_range(0, 2) == 0);
      b.ack = (sent > acked) && ($urandom_range(0, 1) == 1); b.err = 1'b0;
      if (b.ack && $urandom_range(0, 11) == 0) begin b.ack = 1'b0; b.err = 1'b1; end
      if ($urandom_range(0, 24) == 0) chaos();
      step();
      if (b.cyc && b.stb && !b.stall) sent++;
      if (b.cyc && (b.ack || b.err)) acked++;
      erred = b.err;
      ncyc++;
      if (abort && $urandom_range(0, 3) == 0) return;
    end
    b = '0; step();
  endtask

  initial begin
    int exp_out[7] = '{0, 1, 2, 3, 2, 1, 0};
    rst = 1'b1; b = '0;
    @(posedge clk); #1;
    step();
    chk_en = 1;

    // reset state
    rst = 1'b0; #2;
    chk("rst.nreqs", 32'(x_nreqs), 0);
    chk("rst.outstanding", 32'(x_out), 0);
    chk("rst.violation", 32'(x_viol), 0);
    step();

    // single read
    bus(1, 1, 0, 0, 0, 32'h10); step();
    bus(1, 0, 0, 1, 0, 32'h10); #2;
    chk("rd.nreqs_t1", 32'(x_nreqs), 1);
    chk("rd.out_t1", 32'(x_out), 1);
    step();
    bus(0, 0, 0, 0, 0, 32'h0); #2;
    chk("rd.out_t2", 32'(x_out), 0);
    chk("rd.viol_x", 32'(x_viol), 0);
    chk("rd.viol_y", 32'(y_viol), 0);
    step();

    // address changes while stalled
    do_reset(); step();
    bus(1, 1, 1, 0, 0, 32'h10); step();
    bus(1, 1, 0, 0, 0, 32'h14); step();
    bus(1, 0, 0, 1, 0, 32'h14); #2;
    chk("stall_addr.viol_x", 32'(x_viol), 1);
    chk("stall_addr.viol_y", 32'(y_viol), 1);
    step();
    bus(0, 0, 0, 0, 0, 32'h0); step();

    // ack with CYC low, then reset clears
    do_reset(); step();
    bus(0, 0, 0, 1, 0, 32'h0); step();
    bus(0, 0, 0, 0, 0, 32'h0); #2;
    chk("stray_ack.viol_x", 32'(x_viol), 2);
    chk("stray_ack.viol_y", 32'(y_viol), 2);
    do_reset(); #2;
    chk("stray_ack.cleared", 32'(x_viol), 0);
    step();

    // ack delay beyond limit of 2
    bus(1, 1, 0, 0, 0, 32'h40); step();
    bus(1, 0, 0, 0, 0, 32'h40); step(); step(); #2;
    chk("delay.before", 32'(x_viol), 0);
    step();
    bus(1, 0, 0, 1, 0, 32'h40); #2;
    chk("delay.viol_x", 32'(x_viol), 2);
    chk("delay.viol_y", 32'(y_viol), 0);
    step();
    bus(0, 0, 0, 0, 0, 32'h0); step();

    // STB re-rises inside one bus cycle
    do_reset(); step();
    bus(1, 1, 0, 0, 0, 32'h50); step();
    bus(1, 0, 0, 1, 0, 32'h50); step();
    bus(1, 1, 0, 0, 0, 32'h54); step();
    bus(1, 0, 0, 1, 0, 32'h54); #2;
    chk("discont.viol_x", 32'(x_viol), 1);
    chk("discont.viol_y", 32'(y_viol), 0);
    step();
    bus(0, 0, 0, 0, 0, 32'h0); step();

    // CYC held after an err response
    do_reset(); step();
    bus(1, 1, 0, 0, 0, 32'h60); step();
    bus(1, 0, 0, 0, 1, 32'h60); step();
    bus(1, 0, 0, 0, 0, 32'h60); step();
    bus(0, 0, 0, 0, 0, 32'h0); #2;
    chk("err_hold.viol_x", 32'(x_viol), 1);
    chk("err_hold.viol_y", 32'(y_viol), 1);
    step();

    // three pipelined requests then three acks
    do_reset(); step();
    for (int t = 0; t < 7; t++) begin
      if (t < 3)      bus(1, 1, 0, 0, 0, 32'h20 + 32'(t * 4));
      else if (t < 6) bus(1, 0, 0, 1, 0, 32'h28);
      else            bus(0, 0, 0, 0, 0, 32'h0);
      #2;
      chk($sformatf("pipe.out_t%0d", t), 32'(x_out), 32'(exp_out[t]));
      step();
    end
    #2;
    chk("pipe.viol_x", 32'(x_viol), 0);
    chk("pipe.viol_y", 32'(y_viol), 0);

    for (int e = 0; e < 150; e++) episode();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
